slc3_mem_io: RTL and testbench
==============================

Name: slc3_mem_io

Overview:
- Memory and I/O subsystem directly downstream of the SLC-3 CPU core.
- Consumes the core's mem_addr (MAR), mem_wdata (MDR), mem_mem_ena and mem_wr_ena, and returns mem_rdata.
- Contains on-chip word RAM, two memory-mapped I/O registers (hex display and LEDs), a switch-input synchronizer and a time-multiplexed 4-digit seven-segment scanner.

Parameters:
ADDR_WIDTH, 10, RAM address bits; depth = 2**ADDR_WIDTH 16-bit words.
SCAN_BITS, 16, width of free-running display-scan counter; its top 2 bits select the digit.

Ports:
clk  in  1  system clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
mem_addr  in  16  word address from the core.
mem_wdata  in  16  write data from the core.
mem_mem_ena  in  1  access enable; one access per cycle while high.
mem_wr_ena  in  1  1 = write, 0 = read; qualified by mem_mem_ena.
mem_rdata  out  16  registered read data to the core.
sw_i  in  16  asynchronous board switches.
led_o  out  16  LED register contents.
hex_seg_o  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
hex_grid_o  out  4  active-low digit enables; bit 0 = rightmost digit.

Behaviour:
- Reset (async, active-high): mem_rdata=0, hex_reg=0, led_o=0, both sync stages=0, scan counter=0, hex_seg_o=8'hFF, hex_grid_o=4'hF. RAM contents are not reset.
- Address decode, exact 16-bit compare:
  - 16'hFFFF = IO_HEX_SW.
  - 16'hFFFE = IO_LED.
  - All other addresses go to RAM at mem_addr[ADDR_WIDTH-1:0]. Upper bits are ignored, so RAM aliases.
- Write (mem_mem_ena=1, mem_wr_ena=1 at the rising edge):
  - IO_HEX_SW: hex_reg <= mem_wdata.
  - IO_LED: led_o <= mem_wdata.
  - Otherwise: RAM[idx] <= mem_wdata.
  - mem_rdata is unchanged.
- Read (mem_mem_ena=1, mem_wr_ena=0):
  - mem_rdata is loaded at the rising edge and is valid in the following cycle (latency 1).
  - mem_rdata holds until the next read.
  - IO_HEX_SW returns sw_sync; IO_LED returns led_o; otherwise returns RAM[idx] (old data).
- Idle (mem_mem_ena=0): no state change except the synchronizer and scanner.
- Back-to-back: a write to address A in cycle n followed by a read of A in cycle n+1 returns the new data at n+2.
- mem_wr_ena while mem_mem_ena=0 is ignored.
- Switch synchronizer: sw_i passes through two flops (sw_meta, sw_sync) every cycle. A change on sw_i is visible to a read sampled at edge k if it was stable before edge k-2.
- Display scanner:
  - scan_cnt increments every cycle and wraps from 2**SCAN_BITS-1 to 0.
  - digit = scan_cnt[SCAN_BITS-1:SCAN_BITS-2].
  - On each rising edge, hex_grid_o is set to an active-low one-hot of the digit (digit 0 -> 4'b1110, digit 3 -> 4'b0111).
  - On the same edge, hex_seg_o is set to the decode of nibble hex_reg[4*digit+3:4*digit]. Both use the pre-increment counter value, so outputs lag the counter by one cycle.
  - Decode covers 0-F as standard hex glyphs, active low: 0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E as {g..a}. dp (bit 7) is always 1.
  - A hex_reg write takes effect on the segments at the next scan edge showing that digit; there is no blanking.
- Reset mid-operation: all registered outputs return to reset values immediately and asynchronously. RAM writes in flight are dropped. The first access after deassertion behaves normally.
- No X-propagation to mem_rdata: reads of never-written RAM may return any value, but never X out of IO registers.

Test Plan:
- Reset, then idle 4 cycles -> mem_rdata=0, led_o=0, hex_seg_o=8'hFF until the first scan edge, then digit 0 shows '0' (hex_seg_o=8'hC0, hex_grid_o=4'hE).
- Write 16'h1234 to 16'h0005, then read 16'h0005 next cycle -> mem_rdata=16'h1234 one cycle after the read; a read of 16'h0405 (alias, ADDR_WIDTH=10) also returns 16'h1234.
- Write 16'hBEEF to 16'hFFFE -> led_o=16'hBEEF the following cycle; a read of 16'hFFFE returns 16'hBEEF; RAM[10'h3FE] is unchanged.
- sw_i=16'hA5A5 stable for 3 cycles, then read 16'hFFFF -> mem_rdata=16'hA5A5. Changing sw_i one cycle before the read sample -> mem_rdata returns the old value.
- SCAN_BITS=4, write 16'hF80A to 16'hFFFF -> over 16 cycles the grid steps through 1110, 1101, 1011, 0111 with segs 8'h88('A'), 8'hC0('0'), 8'h80('8'), 8'h8E('F'), 4 cycles each, one-cycle lag; the counter wraps back to digit 0.
- Assert reset for one cycle mid-read and mid-write -> mem_rdata=0, led_o=0, hex_grid_o=4'hF immediately. A read after deassertion returns correct RAM data for addresses written before reset.

Source files
------------

// File: rtl/slc3_mem_io.sv
// Memory and I/O subsystem behind the SLC-3 core: word RAM, hex/LED registers,
// switch synchronizer and a time-multiplexed 4-digit seven-segment scanner.
module slc3_mem_io #(
    parameter int ADDR_WIDTH = 10,
    parameter int SCAN_BITS  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        mem_mem_ena,
    input  logic        mem_wr_ena,
    output logic [15:0] mem_rdata,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic [7:0]  hex_seg_o,
    output logic [3:0]  hex_grid_o
);

    localparam logic [15:0] IO_HEX_SW = 16'hFFFF;
    localparam logic [15:0] IO_LED    = 16'hFFFE;
    localparam int          DEPTH     = 1 << ADDR_WIDTH;

    logic                  sel_hex;
    logic                  sel_led;
    logic                  sel_ram;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] ram_idx;

    assign sel_hex = (mem_addr == IO_HEX_SW);
    assign sel_led = (mem_addr == IO_LED);
    assign sel_ram = !sel_hex && !sel_led;
    assign wr_en   = mem_mem_ena && mem_wr_ena;
    assign rd_en   = mem_mem_ena && !mem_wr_ena;
    assign ram_idx = mem_addr[ADDR_WIDTH-1:0];

    logic [15:0] ram [DEPTH];
    logic [15:0] hex_reg;
    logic [15:0] sw_meta_reg;
    logic [15:0] sw_sync_reg;

    // RAM contents survive reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset) begin
            if (wr_en && sel_ram) begin
                ram[ram_idx] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rdata <= 16'h0000;
            hex_reg   <= 16'h0000;
            led_o     <= 16'h0000;
        end else begin
            if (wr_en && sel_hex) begin
                hex_reg <= mem_wdata;
            end
            if (wr_en && sel_led) begin
                led_o <= mem_wdata;
            end
            if (rd_en) begin
                if (sel_hex) begin
                    mem_rdata <= sw_sync_reg;
                end else if (sel_led) begin
                    mem_rdata <= led_o;
                end else begin
                    mem_rdata <= ram[ram_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_reg <= 16'h0000;
            sw_sync_reg <= 16'h0000;
        end else begin
            sw_meta_reg <= sw_i;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    logic [SCAN_BITS-1:0] scan_cnt_reg;
    logic [1:0]           digit;
    logic [3:0]           nibble [4];
    logic [3:0]           grid_next;
    logic [6:0]           seg_next;

    assign digit = scan_cnt_reg[SCAN_BITS-1 -: 2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign nibble[gi]    = hex_reg[4*gi +: 4];
            assign grid_next[gi] = (digit != 2'(gi));
        end
    endgenerate

    // Active-low glyphs as {g,f,e,d,c,b,a}.
    always_comb begin
        seg_next = 7'h7F;
        case (nibble[digit])
            4'h0: seg_next = 7'h40;
            4'h1: seg_next = 7'h79;
            4'h2: seg_next = 7'h24;
            4'h3: seg_next = 7'h30;
            4'h4: seg_next = 7'h19;
            4'h5: seg_next = 7'h12;
            4'h6: seg_next = 7'h02;
            4'h7: seg_next = 7'h78;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h10;
            4'hA: seg_next = 7'h08;
            4'hB: seg_next = 7'h03;
            4'hC: seg_next = 7'h46;
            4'hD: seg_next = 7'h21;
            4'hE: seg_next = 7'h06;
            4'hF: seg_next = 7'h0E;
            default: seg_next = 7'h7F;
        endcase
    end

    // Outputs use the pre-increment count, so they trail the counter by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_reg <= '0;
            hex_grid_o   <= 4'hF;
            hex_seg_o    <= 8'hFF;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SCAN_BITS'(1);
            hex_grid_o   <= grid_next;
            hex_seg_o    <= {1'b1, seg_next};
        end
    end

endmodule

// File: tb/tb_slc3_mem_io.sv
// Directed self-checking bench for slc3_mem_io (ADDR_WIDTH=10, SCAN_BITS=4).
module tb_slc3_mem_io;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_mem_ena;
    logic        mem_wr_ena;
    logic [15:0] mem_rdata;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic [7:0]  hex_seg_o;
    logic [3:0]  hex_grid_o;

    int checks   = 0;
    int failures = 0;

    logic [3:0] model_cnt;
    logic [3:0] pre_cnt;
    logic [1:0] exp_digit;
    logic [7:0] exp_seg_tab [4] = '{8'h88, 8'hC0, 8'h80, 8'h8E};

    slc3_mem_io #(.ADDR_WIDTH(10), .SCAN_BITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_mem_ena (mem_mem_ena),
        .mem_wr_ena  (mem_wr_ena),
        .mem_rdata   (mem_rdata),
        .sw_i        (sw_i),
        .led_o       (led_o),
        .hex_seg_o   (hex_seg_o),
        .hex_grid_o  (hex_grid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) model_cnt <= 4'd0;
        else       model_cnt <= model_cnt + 4'd1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        mem_addr = a; mem_wdata = d; mem_mem_ena = 1'b1; mem_wr_ena = 1'b1;
        @(negedge clk);
        mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a);
        mem_addr = a; mem_mem_ena = 1'b1; mem_wr_ena = 1'b0;
        @(negedge clk);
        mem_mem_ena = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_addr = 16'h0; mem_wdata = 16'h0;
        mem_mem_ena = 1'b0; mem_wr_ena = 1'b0; sw_i = 16'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_rdata", mem_rdata, 16'h0000);
        check("rst_led", led_o, 16'h0000);
        check("rst_seg", {8'h0, hex_seg_o}, 16'h00FF);
        check("rst_grid", {12'h0, hex_grid_o}, 16'h000F);
        reset = 1'b0;
        #1;
        check("pre_scan_seg", {8'h0, hex_seg_o}, 16'h00FF);
        @(negedge clk);
        check("first_scan_seg", {8'h0, hex_seg_o}, 16'h00C0);
        check("first_scan_grid", {12'h0, hex_grid_o}, 16'h000E);
        repeat (3) @(negedge clk);
        check("idle_rdata", mem_rdata, 16'h0000);
        check("idle_led", led_o, 16'h0000);

        // RAM write then back-to-back read, and aliasing of upper address bits
        do_write(16'h0005, 16'h1234);
        do_read(16'h0005);
        check("ram_b2b_read", mem_rdata, 16'h1234);
        do_read(16'h0405);
        check("ram_alias_read", mem_rdata, 16'h1234);
        do_write(16'h03FE, 16'h5555);
        do_write(16'h0007, 16'h1111);
        check("write_keeps_rdata", mem_rdata, 16'h1234);

        // write strobe without enable must be ignored
        mem_addr = 16'h0005; mem_wdata = 16'hDEAD; mem_wr_ena = 1'b1; mem_mem_ena = 1'b0;
        @(negedge clk);
        mem_wr_ena = 1'b0;
        do_read(16'h0005);
        check("wr_no_ena_ignored", mem_rdata, 16'h1234);

        // LED register
        do_write(16'hFFFE, 16'hBEEF);
        check("led_write", led_o, 16'hBEEF);
        check("led_write_rdata_hold", mem_rdata, 16'h1234);
        do_read(16'hFFFE);
        check("led_read", mem_rdata, 16'hBEEF);
        do_read(16'h03FE);
        check("ram_3fe_untouched", mem_rdata, 16'h5555);
        repeat (2) @(negedge clk);
        check("rdata_hold_idle", mem_rdata, 16'h5555);

        // switch synchronizer
        sw_i = 16'hA5A5;
        repeat (3) @(negedge clk);
        do_read(16'hFFFF);
        check("sw_read_stable", mem_rdata, 16'hA5A5);
        sw_i = 16'h3C3C;
        @(negedge clk);
        do_read(16'hFFFF);
        check("sw_read_late_old", mem_rdata, 16'hA5A5);
        do_read(16'hFFFF);
        check("sw_read_new", mem_rdata, 16'h3C3C);

        // display scan over one full counter period
        do_write(16'hFFFF, 16'hF80A);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pre_cnt   = model_cnt - 4'd1;
            exp_digit = pre_cnt[3:2];
            check($sformatf("scan_grid_%0d", i), {12'h0, hex_grid_o}, {12'h0, ~(4'b0001 << exp_digit)});
            check($sformatf("scan_seg_%0d", i), {8'h0, hex_seg_o}, {8'h0, exp_seg_tab[exp_digit]});
        end

        // asynchronous reset in the middle of a read, held across a write
        do_read(16'hFFFE);
        check("pre_reset_rdata", mem_rdata, 16'hBEEF);
        mem_addr = 16'h0005; mem_mem_ena = 1'b1; mem_wr_ena = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_rdata", mem_rdata, 16'h0000);
        check("midrst_led", led_o, 16'h0000);
        check("midrst_grid", {12'h0, hex_grid_o}, 16'h000F);
        check("midrst_seg", {8'h0, hex_seg_o}, 16'h00FF);
        @(negedge clk);
        mem_addr = 16'h0007; mem_wdata = 16'h7777; mem_mem_ena = 1'b1; mem_wr_ena = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
        do_read(16'h0007);
        check("post_rst_dropped_write", mem_rdata, 16'h1111);
        do_read(16'h0005);
        check("post_rst_ram", mem_rdata, 16'h1234);
        check("post_rst_led", led_o, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
